// File: rtl/rs_issue_select_if.sv
// Dispatch / wakeup / issue / slot-return bundle for one reservation station.
// The station takes the slave modport; the dispatch and execute side takes the master modport.
interface rs_issue_select_if #(
  parameter int unsigned NUM_RS_ENTRIES = 8,
  parameter int unsigned PHYS_TAG_W     = 6,
  parameter int unsigned PAYLOAD_W      = 64
);
  localparam int unsigned SLOT_W = $clog2(NUM_RS_ENTRIES);

  logic                  disp_valid_0;
  logic [SLOT_W-1:0]     disp_slot_0;
  logic [PHYS_TAG_W-1:0] disp_src1_tag_0;
  logic                  disp_src1_rdy_0;
  logic [PHYS_TAG_W-1:0] disp_src2_tag_0;
  logic                  disp_src2_rdy_0;
  logic [PAYLOAD_W-1:0]  disp_payload_0;

  logic                  disp_valid_1;
  logic [SLOT_W-1:0]     disp_slot_1;
  logic [PHYS_TAG_W-1:0] disp_src1_tag_1;
  logic                  disp_src1_rdy_1;
  logic [PHYS_TAG_W-1:0] disp_src2_tag_1;
  logic                  disp_src2_rdy_1;
  logic [PAYLOAD_W-1:0]  disp_payload_1;

  logic                  wake_valid_0;
  logic [PHYS_TAG_W-1:0] wake_tag_0;
  logic                  wake_valid_1;
  logic [PHYS_TAG_W-1:0] wake_tag_1;

  logic                  issue_valid;
  logic                  issue_ready;
  logic [SLOT_W-1:0]     issue_slot;
  logic [PHYS_TAG_W-1:0] issue_src1_tag;
  logic [PHYS_TAG_W-1:0] issue_src2_tag;
  logic [PAYLOAD_W-1:0]  issue_payload;

  logic                  return_slot_valid;
  logic [SLOT_W-1:0]     return_slot;
  logic [SLOT_W:0]       occupancy;
  logic                  disp_err;

  modport master (
    output disp_valid_0, disp_slot_0, disp_src1_tag_0, disp_src1_rdy_0,
           disp_src2_tag_0, disp_src2_rdy_0, disp_payload_0,
    output disp_valid_1, disp_slot_1, disp_src1_tag_1, disp_src1_rdy_1,
           disp_src2_tag_1, disp_src2_rdy_1, disp_payload_1,
    output wake_valid_0, wake_tag_0, wake_valid_1, wake_tag_1,
    output issue_ready,
    input  issue_valid, issue_slot, issue_src1_tag, issue_src2_tag, issue_payload,
    input  return_slot_valid, return_slot, occupancy, disp_err
  );

  modport slave (
    input  disp_valid_0, disp_slot_0, disp_src1_tag_0, disp_src1_rdy_0,
           disp_src2_tag_0, disp_src2_rdy_0, disp_payload_0,
    input  disp_valid_1, disp_slot_1, disp_src1_tag_1, disp_src1_rdy_1,
           disp_src2_tag_1, disp_src2_rdy_1, disp_payload_1,
    input  wake_valid_0, wake_tag_0, wake_valid_1, wake_tag_1,
    input  issue_ready,
    output issue_valid, issue_slot, issue_src1_tag, issue_src2_tag, issue_payload,
    output return_slot_valid, return_slot, occupancy, disp_err
  );
endinterface

// File: rtl/rs_issue_select.sv
// Reservation station: holds dispatched uops, wakes sources on CDB tags, issues one ready entry per cycle.
// Define RS_AGE_SELECT_EN for oldest-ready-first select (age matrix); otherwise lowest index wins.
module rs_issue_select #(
  parameter int unsigned NUM_RS_ENTRIES = 8,
  parameter int unsigned PHYS_TAG_W     = 6,
  parameter int unsigned PAYLOAD_W      = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  rs_issue_select_if.slave    bus
);
  localparam int unsigned SLOT_W = $clog2(NUM_RS_ENTRIES);
  localparam int unsigned N      = NUM_RS_ENTRIES;

  typedef logic [PHYS_TAG_W-1:0] tag_t;
  typedef logic [PAYLOAD_W-1:0]  pay_t;

  logic [N-1:0] r_valid, r_s1_rdy, r_s2_rdy;
  tag_t         r_s1_tag  [N];
  tag_t         r_s2_tag  [N];
  pay_t         r_payload [N];
  logic         r_ret_valid;
  logic [SLOT_W-1:0] r_ret_slot;
  logic         r_disp_err;

  logic [N-1:0] w_valid_nxt, w_s1_rdy_nxt, w_s2_rdy_nxt;
  tag_t         w_s1_tag_nxt  [N];
  tag_t         w_s2_tag_nxt  [N];
  pay_t         w_payload_nxt [N];
  logic         w_disp_err_nxt;

  logic [N-1:0] w_ready;
  logic [N-1:0] w_cand;
  logic         w_sel_valid;
  logic [SLOT_W-1:0] w_sel_idx;
  logic         w_fire;
  logic [SLOT_W:0] w_occ;

  function automatic logic wake_hit(input tag_t t, input logic v0, input tag_t t0,
                                    input logic v1, input tag_t t1);
    return (v0 && (t0 == t)) || (v1 && (t1 == t));
  endfunction

  assign w_ready = r_valid & r_s1_rdy & r_s2_rdy;

`ifdef RS_AGE_SELECT_EN
  // r_age[i][j] = 1 means entry i is older than entry j.
  logic [N-1:0] r_age     [N];
  logic [N-1:0] w_age_nxt [N];

  always_comb begin
    w_cand = w_ready;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (w_ready[j] && r_age[j][i]) w_cand[i] = 1'b0;
      end
    end
  end

  // Fire clears the freed entry's relations; new entries are younger than every survivor
  // and lane 0 is older than lane 1.
  always_comb begin
    logic [N-1:0] v_live;
    w_age_nxt = r_age;
    v_live    = r_valid;
    if (w_fire) begin
      v_live[w_sel_idx]     = 1'b0;
      w_age_nxt[w_sel_idx]  = '0;
      for (int unsigned j = 0; j < N; j++) w_age_nxt[j][w_sel_idx] = 1'b0;
    end
    if (bus.disp_valid_0) begin
      w_age_nxt[bus.disp_slot_0] = '0;
      for (int unsigned j = 0; j < N; j++)
        if (SLOT_W'(j) != bus.disp_slot_0) w_age_nxt[j][bus.disp_slot_0] = v_live[j];
      v_live[bus.disp_slot_0] = 1'b1;
    end
    if (bus.disp_valid_1) begin
      w_age_nxt[bus.disp_slot_1] = '0;
      for (int unsigned j = 0; j < N; j++)
        if (SLOT_W'(j) != bus.disp_slot_1) w_age_nxt[j][bus.disp_slot_1] = v_live[j];
    end
    if (flush) begin
      for (int unsigned i = 0; i < N; i++) w_age_nxt[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) r_age[i] <= '0;
    end else begin
      r_age <= w_age_nxt;
    end
  end
`else
  assign w_cand = w_ready;
`endif

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_cand[i] && !w_sel_valid) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = SLOT_W'(i);
      end
    end
  end

  assign w_fire = w_sel_valid && bus.issue_ready && !flush;

  always_comb begin
    w_valid_nxt   = r_valid;
    w_s1_rdy_nxt  = r_s1_rdy;
    w_s2_rdy_nxt  = r_s2_rdy;
    w_s1_tag_nxt  = r_s1_tag;
    w_s2_tag_nxt  = r_s2_tag;
    w_payload_nxt = r_payload;
    w_disp_err_nxt = r_disp_err;
    for (int unsigned i = 0; i < N; i++) begin
      if (r_valid[i] && wake_hit(r_s1_tag[i], bus.wake_valid_0, bus.wake_tag_0,
                                 bus.wake_valid_1, bus.wake_tag_1))
        w_s1_rdy_nxt[i] = 1'b1;
      if (r_valid[i] && wake_hit(r_s2_tag[i], bus.wake_valid_0, bus.wake_tag_0,
                                 bus.wake_valid_1, bus.wake_tag_1))
        w_s2_rdy_nxt[i] = 1'b1;
    end
    if (w_fire) w_valid_nxt[w_sel_idx] = 1'b0;
    // Lane 1 is applied last so it overwrites lane 0 on a slot collision.
    if (bus.disp_valid_0) begin
      w_valid_nxt[bus.disp_slot_0]   = 1'b1;
      w_s1_tag_nxt[bus.disp_slot_0]  = bus.disp_src1_tag_0;
      w_s2_tag_nxt[bus.disp_slot_0]  = bus.disp_src2_tag_0;
      w_payload_nxt[bus.disp_slot_0] = bus.disp_payload_0;
      w_s1_rdy_nxt[bus.disp_slot_0]  = bus.disp_src1_rdy_0 ||
        wake_hit(bus.disp_src1_tag_0, bus.wake_valid_0, bus.wake_tag_0, bus.wake_valid_1, bus.wake_tag_1);
      w_s2_rdy_nxt[bus.disp_slot_0]  = bus.disp_src2_rdy_0 ||
        wake_hit(bus.disp_src2_tag_0, bus.wake_valid_0, bus.wake_tag_0, bus.wake_valid_1, bus.wake_tag_1);
      if (r_valid[bus.disp_slot_0] && !flush) w_disp_err_nxt = 1'b1;
    end
    if (bus.disp_valid_1) begin
      w_valid_nxt[bus.disp_slot_1]   = 1'b1;
      w_s1_tag_nxt[bus.disp_slot_1]  = bus.disp_src1_tag_1;
      w_s2_tag_nxt[bus.disp_slot_1]  = bus.disp_src2_tag_1;
      w_payload_nxt[bus.disp_slot_1] = bus.disp_payload_1;
      w_s1_rdy_nxt[bus.disp_slot_1]  = bus.disp_src1_rdy_1 ||
        wake_hit(bus.disp_src1_tag_1, bus.wake_valid_0, bus.wake_tag_0, bus.wake_valid_1, bus.wake_tag_1);
      w_s2_rdy_nxt[bus.disp_slot_1]  = bus.disp_src2_rdy_1 ||
        wake_hit(bus.disp_src2_tag_1, bus.wake_valid_0, bus.wake_tag_0, bus.wake_valid_1, bus.wake_tag_1);
      if (r_valid[bus.disp_slot_1] && !flush) w_disp_err_nxt = 1'b1;
    end
    if (bus.disp_valid_0 && bus.disp_valid_1 && (bus.disp_slot_0 == bus.disp_slot_1) && !flush)
      w_disp_err_nxt = 1'b1;
    if (flush) w_valid_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= '0;
      r_s1_rdy    <= '0;
      r_s2_rdy    <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        r_s1_tag[i]  <= '0;
        r_s2_tag[i]  <= '0;
        r_payload[i] <= '0;
      end
      r_ret_valid <= 1'b0;
      r_ret_slot  <= '0;
      r_disp_err  <= 1'b0;
    end else begin
      r_valid     <= w_valid_nxt;
      r_s1_rdy    <= w_s1_rdy_nxt;
      r_s2_rdy    <= w_s2_rdy_nxt;
      r_s1_tag    <= w_s1_tag_nxt;
      r_s2_tag    <= w_s2_tag_nxt;
      r_payload   <= w_payload_nxt;
      r_ret_valid <= w_fire;
      if (w_fire) r_ret_slot <= w_sel_idx;
      r_disp_err  <= w_disp_err_nxt;
    end
  end

  // Occupancy is the live-entry count, which equals the dispatch/fire running sum under legal use.
  always_comb begin
    w_occ = '0;
    for (int unsigned i = 0; i < N; i++) w_occ = w_occ + (SLOT_W+1)'(r_valid[i]);
  end

  assign bus.issue_valid       = w_sel_valid;
  assign bus.issue_slot        = w_sel_idx;
  assign bus.issue_src1_tag    = w_sel_valid ? r_s1_tag[w_sel_idx]  : '0;
  assign bus.issue_src2_tag    = w_sel_valid ? r_s2_tag[w_sel_idx]  : '0;
  assign bus.issue_payload     = w_sel_valid ? r_payload[w_sel_idx] : '0;
  assign bus.return_slot_valid = r_ret_valid;
  assign bus.return_slot       = r_ret_slot;
  assign bus.occupancy         = w_occ;
  assign bus.disp_err          = r_disp_err;
endmodule

// File: tb/tb_rs_issue_select.sv
// Directed bench for rs_issue_select: issue, wakeup, bypass, select order, flush, collision, reset.
module tb_rs_issue_select;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  rs_issue_select_if #(.NUM_RS_ENTRIES(8), .PHYS_TAG_W(6), .PAYLOAD_W(64)) bus ();
  rs_issue_select #(.NUM_RS_ENTRIES(8), .PHYS_TAG_W(6), .PAYLOAD_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lane0(input logic [2:0] s, input logic [5:0] t1, input logic r1,
                       input logic [5:0] t2, input logic r2, input logic [63:0] p);
    bus.disp_valid_0 = 1'b1; bus.disp_slot_0 = s;
    bus.disp_src1_tag_0 = t1; bus.disp_src1_rdy_0 = r1;
    bus.disp_src2_tag_0 = t2; bus.disp_src2_rdy_0 = r2;
    bus.disp_payload_0 = p;
  endtask

  task automatic lane1(input logic [2:0] s, input logic [5:0] t1, input logic r1,
                       input logic [5:0] t2, input logic r2, input logic [63:0] p);
    bus.disp_valid_1 = 1'b1; bus.disp_slot_1 = s;
    bus.disp_src1_tag_1 = t1; bus.disp_src1_rdy_1 = r1;
    bus.disp_src2_tag_1 = t2; bus.disp_src2_rdy_1 = r2;
    bus.disp_payload_1 = p;
  endtask

  task automatic idle();
    bus.disp_valid_0 = 1'b0; bus.disp_valid_1 = 1'b0;
    bus.wake_valid_0 = 1'b0; bus.wake_valid_1 = 1'b0;
  endtask

  logic [2:0] first_sel, second_sel;

  initial begin
    idle();
    lane0(3'd0, '0, 1'b0, '0, 1'b0, '0);
    lane1(3'd0, '0, 1'b0, '0, 1'b0, '0);
    idle();
    bus.wake_tag_0 = '0; bus.wake_tag_1 = '0;
    bus.issue_ready = 1'b0;
`ifdef RS_AGE_SELECT_EN
    first_sel = 3'd6; second_sel = 3'd1;
`else
    first_sel = 3'd1; second_sel = 3'd6;
`endif
    tick(); tick();
    check("rst_issue_valid", bus.issue_valid, 0);
    check("rst_issue_slot", bus.issue_slot, 0);
    check("rst_issue_payload", bus.issue_payload, 0);
    check("rst_ret_valid", bus.return_slot_valid, 0);
    check("rst_ret_slot", bus.return_slot, 0);
    check("rst_occ", bus.occupancy, 0);
    check("rst_disp_err", bus.disp_err, 0);
    rst_n = 1'b1;
    tick();

    // 1: ready-at-dispatch entry issues next cycle, returns the cycle after fire
    lane0(3'd3, 6'd1, 1'b1, 6'd2, 1'b1, 64'hA3);
    check("t1_no_zero_cycle", bus.issue_valid, 0);
    tick(); idle();
    check("t1_issue_valid", bus.issue_valid, 1);
    check("t1_issue_slot", bus.issue_slot, 3);
    check("t1_payload", bus.issue_payload, 64'hA3);
    check("t1_src1", bus.issue_src1_tag, 1);
    check("t1_src2", bus.issue_src2_tag, 2);
    check("t1_occ1", bus.occupancy, 1);
    check("t1_ret_before", bus.return_slot_valid, 0);
    bus.issue_ready = 1'b1;
    tick(); bus.issue_ready = 1'b0;
    check("t1_ret_valid", bus.return_slot_valid, 1);
    check("t1_ret_slot", bus.return_slot, 3);
    check("t1_occ0", bus.occupancy, 0);
    check("t1_issue_gone", bus.issue_valid, 0);
    tick();
    check("t1_ret_pulse", bus.return_slot_valid, 0);

    // 2: wake on CDB port 1 two cycles after dispatch
    lane0(3'd2, 6'd9, 1'b0, 6'd3, 1'b1, 64'hB2);
    tick(); idle();
    check("t2_wait0", bus.issue_valid, 0);
    bus.wake_valid_0 = 1'b1; bus.wake_tag_0 = 6'd10;
    tick(); idle();
    check("t2_nomatch", bus.issue_valid, 0);
    bus.wake_valid_1 = 1'b1; bus.wake_tag_1 = 6'd9;
    check("t2_wake_cycle", bus.issue_valid, 0);
    tick(); idle();
    check("t2_issue_valid", bus.issue_valid, 1);
    check("t2_issue_slot", bus.issue_slot, 2);
    bus.issue_ready = 1'b1;
    tick(); bus.issue_ready = 1'b0;
    check("t2_ret_slot", bus.return_slot, 2);
    check("t2_occ", bus.occupancy, 0);

    // 2b: both CDB ports wake different sources of one entry together
    lane0(3'd0, 6'd30, 1'b0, 6'd31, 1'b0, 64'h77);
    tick(); idle();
    bus.wake_valid_0 = 1'b1; bus.wake_tag_0 = 6'd31;
    bus.wake_valid_1 = 1'b1; bus.wake_tag_1 = 6'd30;
    tick(); idle();
    check("t2b_issue_valid", bus.issue_valid, 1);
    check("t2b_issue_slot", bus.issue_slot, 0);
    bus.issue_ready = 1'b1;
    tick(); bus.issue_ready = 1'b0;
    check("t2b_ret_slot", bus.return_slot, 0);

    // 3: same-cycle wakeup bypass into the dispatched entry
    lane0(3'd5, 6'd4, 1'b1, 6'd12, 1'b0, 64'hC5);
    bus.wake_valid_0 = 1'b1; bus.wake_tag_0 = 6'd12;
    tick(); idle();
    check("t3_issue_valid", bus.issue_valid, 1);
    check("t3_issue_slot", bus.issue_slot, 5);
    bus.issue_ready = 1'b1;
    tick(); bus.issue_ready = 1'b0;
    check("t3_ret_slot", bus.return_slot, 5);

    // 4: select order with backpressure
    lane0(3'd6, 6'd1, 1'b1, 6'd1, 1'b1, 64'h66);
    tick(); idle();
    lane0(3'd1, 6'd1, 1'b1, 6'd1, 1'b1, 64'h11);
    tick(); idle();
    check("t4_sel", bus.issue_slot, first_sel);
    tick(); tick();
    check("t4_hold_valid", bus.issue_valid, 1);
    check("t4_hold_sel", bus.issue_slot, first_sel);
    check("t4_occ2", bus.occupancy, 2);
    bus.issue_ready = 1'b1;
    tick();
    check("t4_ret_first", bus.return_slot, first_sel);
    check("t4_next_sel", bus.issue_slot, second_sel);
    tick(); bus.issue_ready = 1'b0;
    check("t4_ret_second", bus.return_slot, second_sel);
    check("t4_ret_second_v", bus.return_slot_valid, 1);
    check("t4_empty", bus.issue_valid, 0);
    tick();

    // 5: fill all slots, flush with fire and dispatch requested in the same cycle
    for (int i = 0; i < 4; i++) begin
      lane0(3'(2*i), 6'd5, 1'b1, 6'd5, 1'b1, 64'(i));
      lane1(3'(2*i+1), 6'd5, 1'b1, 6'd5, 1'b1, 64'(i+16));
      tick(); idle();
    end
    check("t5_full", bus.occupancy, 8);
    check("t5_sel0", bus.issue_slot, 0);
    flush = 1'b1; bus.issue_ready = 1'b1;
    lane0(3'd3, 6'd5, 1'b1, 6'd5, 1'b1, 64'h99);
    tick(); idle();
    flush = 1'b0; bus.issue_ready = 1'b0;
    check("t5_occ0", bus.occupancy, 0);
    check("t5_issue_valid", bus.issue_valid, 0);
    check("t5_no_ret", bus.return_slot_valid, 0);
    check("t5_err_clean", bus.disp_err, 0);
    tick();
    check("t5_no_ret_later", bus.return_slot_valid, 0);

    // 6: lane collision, lane 1 wins, sticky error
    lane0(3'd4, 6'd2, 1'b1, 6'd2, 1'b1, 64'h1111);
    lane1(3'd4, 6'd3, 1'b1, 6'd3, 1'b1, 64'h2222);
    tick(); idle();
    check("t6_err", bus.disp_err, 1);
    check("t6_slot", bus.issue_slot, 4);
    check("t6_payload", bus.issue_payload, 64'h2222);
    check("t6_src1", bus.issue_src1_tag, 3);
    bus.issue_ready = 1'b1;
    tick(); bus.issue_ready = 1'b0;
    tick();
    check("t6_err_sticky", bus.disp_err, 1);

    // async reset mid-cycle clears state without a clock edge
    lane0(3'd7, 6'd8, 1'b0, 6'd8, 1'b0, 64'h7);
    tick(); idle();
    check("t7_occ1", bus.occupancy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_async_occ", bus.occupancy, 0);
    check("t7_async_err", bus.disp_err, 0);
    tick();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
